// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 15;  // word address width, 32768-deep RAM
  localparam int DATA_W = 16;  // word width

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic. Grant is combinational from the
// requests; the last_grant register advances only on a completed handshake.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  port_e last_grant;

  // A lone requester wins; on a tie the port not granted most recently wins.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of each completed handshake; B after reset so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      last_grant <= PORT_B;
    end else if (accept) begin
      last_grant <= gnt[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read RAM.
// Port A and port B share the RAM; the granted request drives the RAM
// combinationally and read data returns to the issuing port one cycle later.
// Optional feature: define RAM_ARB_WRITE_ACK_EN to make every accepted write
// return a one-cycle response with zero data.
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic [1:0]        gnt;
  logic              accept;   // a handshake completes at the next edge
  logic              issue;    // the accepted request expects a response
  ram_req_t          a_req;
  ram_req_t          b_req;
  ram_req_t          sel_req;
  logic [ADDR_W-1:0] last_addr;
  logic              pend_valid;
  port_e             pend_port;
  logic [DATA_W-1:0] rsp_data;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_req_valid, a_req_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign a_req = '{addr: a_addr, we: a_we, wdata: a_wdata};
  assign b_req = '{addr: b_addr, we: b_we, wdata: b_wdata};

  // Grants are only ever raised for valid requesters, so any grant is a handshake.
  assign a_req_ready = gnt[0];
  assign b_req_ready = gnt[1];
  assign accept      = |gnt;
  assign sel_req     = gnt[1] ? b_req : a_req;

  // With no grant the address holds its last granted value and nothing is written.
  assign ram_address      = accept ? sel_req.addr : last_addr;
  assign ram_data         = sel_req.wdata;
  assign ram_write_enable = accept & sel_req.we & ~rst;

`ifdef RAM_ARB_WRITE_ACK_EN
  logic pend_we;

  assign issue    = accept;
  assign rsp_data = pend_we ? '0 : ram_data_out;

  // Track whether the pending response belongs to a write, which returns zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_we <= 1'b0;
    end else if (accept) begin
      pend_we <= sel_req.we;
    end
  end
`else
  assign issue    = accept & ~sel_req.we;
  assign rsp_data = ram_data_out;
`endif

  // Pending-response pipeline and held address; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_port  <= PORT_A;
      last_addr  <= '0;
    end else begin
      pend_valid <= issue;
      if (accept) begin
        pend_port <= gnt[1] ? PORT_B : PORT_A;
        last_addr <= sel_req.addr;
      end
    end
  end

  assign a_rsp_valid = pend_valid & (pend_port == PORT_A);
  assign b_rsp_valid = pend_valid & (pend_port == PORT_B);
  assign a_rdata     = a_rsp_valid ? rsp_data : '0;
  assign b_rdata     = b_rsp_valid ? rsp_data : '0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter placed directly upstream of the 32Ki x 16 single-port `ram`, sharing it between port A (instruction fetch) and port B (data load/store). Accepts at most one request per cycle over a valid/ready handshake. Drives the RAM's address, data and write-enable combinationally from the granted request. Returns read data to the issuing port one cycle later.

## Interface
- `ADDR_W`, 15: word address width; matches RAM depth of 32768.
- `DATA_W`, 16: word width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_req_valid` / `b_req_valid`  in  1  the port presents a request.
- `a_req_ready` / `b_req_ready`  out  1  the request is granted this cycle.
- `a_addr` / `b_addr`  in  ADDR_W  word address.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_wdata` / `b_wdata`  in  DATA_W  write data.
- `a_rsp_valid` / `b_rsp_valid`  out  1  response for this port.
- `a_rdata` / `b_rdata`  out  DATA_W  read data; 0 whenever the matching `rsp_valid` is low.
- `ram_address`  out  ADDR_W  to `ram.address`.
- `ram_data`  out  DATA_W  to `ram.data`.
- `ram_write_enable`  out  1  to `ram.write_enable`.
- `ram_data_out`  in  DATA_W  from `ram.data_out`.

## Operation
- **Grant, combinational:**
  - Exactly one requester: it wins.
  - Both requesting: the port not granted most recently wins.
  - Neither requesting: no grant; `ram_write_enable` = 0; `ram_address` holds the last granted address.
- A handshake completes when `x_req_valid & x_req_ready` at a rising edge.
- **State registers:**
  - `last_grant`: updates only on a completed handshake.
  - `pend_valid`, `pend_port`, `pend_we`: describe the request accepted in the previous cycle.
- **RAM drive:** `ram_address`, `ram_data` and `ram_write_enable` are muxed from the granted port. `ram_write_enable` = granted & `we`.
- **Read response:**
  - Cycle after a read is accepted: `rsp_valid` = 1 for the issuing port only.
  - `rdata` = `ram_data_out`.
- **Write response:** none, except as described under Configuration.
- There is no response backpressure; the ports must consume responses on arrival.
- **Reset values:**
  - `last_grant` = B, so A wins the first tie.
  - `pend_valid` = 0.
  - All `rsp_valid` = 0 and all `rdata` = 0.
- **Reset asserted mid-operation:** any in-flight read is discarded and no response is produced. Request outputs keep following inputs, but `ram_write_enable` is forced to 0 while `rst` is high.
- **Request holding:** a requester that is not granted holds its request unchanged. The arbiter must not depend on this for correctness.

## Timing
- Request to read response: latency 1 cycle.
- Throughput: one access per cycle in aggregate.
- Under sustained contention, grants alternate A, B, A, B.
- Write to address X in cycle N, then read of X in cycle N+1 (either port): the read returns the new data.
- Each port's `rsp_valid` pulses are at most 1 cycle wide per accepted read.

## Configuration
- **`RAM_ARB_WRITE_ACK_EN` defined:**
  - An accepted write produces `rsp_valid` = 1 for its port one cycle later, with `rdata` = 0.
  - Every accepted request then yields exactly one response.
- **`RAM_ARB_WRITE_ACK_EN` undefined:** writes produce no response. `pend_we` may be optimised away.

## Structure
- **`ram_arb_pkg` contents:**
  - `ADDR_W` and `DATA_W` default constants.
  - `typedef enum logic {PORT_A, PORT_B} port_e`.
  - `typedef struct packed {addr, we, wdata} ram_req_t`.
- **`rr_arb2` submodule:** two-requester round-robin grant logic.
  - Inputs: `clk`, `rst`, `req[1:0]`, `accept`.
  - Output: one-hot `gnt[1:0]`.
  - Owns the `last_grant` register.
- `ram_arbiter` holds the request mux and the pending-response pipeline register.

## Test plan
- Reset, then A read of 0x0010 only → `a_req_ready` = 1 the same cycle; `a_rsp_valid` = 1 the next cycle with `a_rdata` = preloaded 0xBEEF; `b_rsp_valid` = 0 throughout.
- A and B both reading continuously for 6 cycles → grant order A, B, A, B, A, B; each response returns on the port that issued it.
- B writes 0x1234 to 0x7FFF in cycle N; A reads 0x7FFF in cycle N+1 → `a_rdata` = 0x1234 in cycle N+2.
- `rst` asserted the cycle after an accepted read → no `rsp_valid`; `ram_write_enable` = 0 during reset; after release, first tie goes to A.
- Write with `RAM_ARB_WRITE_ACK_EN` defined → `rsp_valid` = 1 with `rdata` = 0 one cycle later. Same write with the macro undefined → no response.
- Random A/B traffic against a scoreboard RAM model for 10k cycles → no data mismatch and no lost or duplicated response. No port waits more than 1 cycle while the other is also requesting.
